// File: rtl/sync_bus.sv
// sync_bus: multi-channel single-bit synchroniser with an optional stability
// filter and a registered per-channel edge-event pulse, all in the receiving clock domain.
module sync_bus #(
  parameter int                 WIDTH     = 2,
  parameter int                 STAGES    = 2,
  parameter int                 FILTER    = 0,
  parameter logic [2*WIDTH-1:0] MODE      = {WIDTH{2'b01}},
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk_s,
  input  logic             reset_s,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] lvl_o,
  output logic [WIDTH-1:0] evt_o,
  output logic [WIDTH-1:0] busy_o
);

  localparam int              CW       = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
  localparam logic [CW-1:0]   FILT_MAX = CW'(FILTER);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_bus: WIDTH must be within 1..32");
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_bus: STAGES must be within 2..4");
  end
  if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
    $error("sync_bus: FILTER must be within 0..255");
  end

  // Event qualifier: does accepting new level new_lvl fire a pulse in this mode?
  function automatic logic edge_hit(input logic [1:0] mode, input logic new_lvl);
    case (mode)
      2'b01:   edge_hit = new_lvl;
      2'b10:   edge_hit = ~new_lvl;
      2'b11:   edge_hit = 1'b1;
      default: edge_hit = 1'b0;
    endcase
  endfunction

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] chain_d [STAGES];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] evt_q, evt_d;
  logic [WIDTH-1:0] sync_s;

  always_comb begin
    chain_d[0] = async_i;
    for (int k = 1; k < STAGES; k++) begin
      chain_d[k] = chain_q[k-1];
    end
  end

  always_ff @(posedge clk_s or posedge reset_s) begin
    if (reset_s) begin
      for (int k = 0; k < STAGES; k++) begin
        chain_q[k] <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        chain_q[k] <= chain_d[k];
      end
    end
  end

  assign sync_s = chain_q[STAGES-1];

  // A differing value is accepted only after it has been seen FILTER+1 cycles in a row.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      lvl_d[i] = lvl_q[i];
      evt_d[i] = 1'b0;
      cnt_d[i] = {CW{1'b0}};
      if (sync_s[i] != lvl_q[i]) begin
        if (cnt_q[i] == FILT_MAX) begin
          lvl_d[i] = sync_s[i];
          evt_d[i] = edge_hit(MODE[2*i +: 2], sync_s[i]);
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = {CW{1'b0}};
      end
    end
  end

  always_ff @(posedge clk_s or posedge reset_s) begin
    if (reset_s) begin
      lvl_q <= RESET_VAL;
      evt_q <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      lvl_q <= lvl_d;
      evt_q <= evt_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign lvl_o  = lvl_q;
  assign evt_o  = evt_q;
  assign busy_o = sync_s ^ lvl_q;

endmodule

// File: tb/tb_sync_bus.sv
// tb_sync_bus: six sync_bus configurations driven by directed vectors, checked every
// cycle against a history-based model plus hand-computed latency/pulse expectations.
module tb_sync_bus;

  localparam int NI = 6;
  localparam int       WD [NI] = '{2, 1, 2, 2, 2, 1};
  localparam int       ST [NI] = '{2, 3, 2, 2, 2, 2};
  localparam int       FI [NI] = '{0, 2, 0, 0, 4, 0};
  localparam logic [3:0] MO [NI] = '{4'b0101, 4'b0011, 4'b0101, 4'b1001, 4'b0101, 4'b0011};
  localparam logic [1:0] RV [NI] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam int HN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v;
  logic [1:0]    ain [NI];
  logic [1:0]    l0, e0, b0, l2, e2, b2, l3, e3, b3, l4, e4, b4;
  logic          l1, e1, b1, l5, e5, b5;

  int n_checks = 0;
  int n_errors = 0;

  sync_bus #(.WIDTH(2), .STAGES(ST[0]), .FILTER(FI[0]), .MODE(MO[0]), .RESET_VAL(RV[0])) u0 (
    .clk_s(clk), .reset_s(rst_v[0]), .async_i(ain[0]), .lvl_o(l0), .evt_o(e0), .busy_o(b0));
  sync_bus #(.WIDTH(1), .STAGES(ST[1]), .FILTER(FI[1]), .MODE(MO[1][1:0]), .RESET_VAL(RV[1][0:0])) u1 (
    .clk_s(clk), .reset_s(rst_v[1]), .async_i(ain[1][0:0]), .lvl_o(l1), .evt_o(e1), .busy_o(b1));
  sync_bus #(.WIDTH(2), .STAGES(ST[2]), .FILTER(FI[2]), .MODE(MO[2]), .RESET_VAL(RV[2])) u2 (
    .clk_s(clk), .reset_s(rst_v[2]), .async_i(ain[2]), .lvl_o(l2), .evt_o(e2), .busy_o(b2));
  sync_bus #(.WIDTH(2), .STAGES(ST[3]), .FILTER(FI[3]), .MODE(MO[3]), .RESET_VAL(RV[3])) u3 (
    .clk_s(clk), .reset_s(rst_v[3]), .async_i(ain[3]), .lvl_o(l3), .evt_o(e3), .busy_o(b3));
  sync_bus #(.WIDTH(2), .STAGES(ST[4]), .FILTER(FI[4]), .MODE(MO[4]), .RESET_VAL(RV[4])) u4 (
    .clk_s(clk), .reset_s(rst_v[4]), .async_i(ain[4]), .lvl_o(l4), .evt_o(e4), .busy_o(b4));
  sync_bus #(.WIDTH(1), .STAGES(ST[5]), .FILTER(FI[5]), .MODE(MO[5][1:0]), .RESET_VAL(RV[5][0:0])) u5 (
    .clk_s(clk), .reset_s(rst_v[5]), .async_i(ain[5][0:0]), .lvl_o(l5), .evt_o(e5), .busy_o(b5));

  // Packed view of one instance: {lvl[1:0], evt[1:0], busy[1:0]}
  function automatic logic [5:0] dut_out(input int k);
    case (k)
      0:       dut_out = {l0, e0, b0};
      1:       dut_out = {1'b0, l1, 1'b0, e1, 1'b0, b1};
      2:       dut_out = {l2, e2, b2};
      3:       dut_out = {l3, e3, b3};
      4:       dut_out = {l4, e4, b4};
      default: dut_out = {1'b0, l5, 1'b0, e5, 1'b0, b5};
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: sampled-input history gives sync; the level flips once the last FILTER+1
  // pre-edge sync samples all disagree with it.
  logic ih [NI][2][HN];
  logic sh [NI][2][HN];
  int   ih_n [NI];
  int   sh_n [NI];
  logic lvl_m [NI][2];
  logic evt_m [NI][2];
  logic busy_m [NI][2];

  task automatic model_reset(input int k);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < ST[k]; i++) ih[k][c][i] = RV[k][c];
      lvl_m[k][c]  = RV[k][c];
      evt_m[k][c]  = 1'b0;
      busy_m[k][c] = 1'b0;
    end
    ih_n[k] = ST[k];
    sh_n[k] = 0;
  endtask

  task automatic model_edge(input int k);
    logic acc;
    logic [1:0] m;
    if (rst_v[k]) begin
      model_reset(k);
    end else begin
      for (int c = 0; c < 2; c++) begin
        sh[k][c][sh_n[k]] = ih[k][c][ih_n[k] - ST[k]];
        ih[k][c][ih_n[k]] = ain[k][c];
      end
      ih_n[k]++;
      sh_n[k]++;
      for (int c = 0; c < 2; c++) begin
        acc = (sh_n[k] >= FI[k] + 1);
        for (int j = 1; j <= FI[k] + 1 && acc; j++)
          if (sh[k][c][sh_n[k] - j] == lvl_m[k][c]) acc = 1'b0;
        evt_m[k][c] = 1'b0;
        if (acc) begin
          lvl_m[k][c] = ~lvl_m[k][c];
          m = MO[k][2*c +: 2];
          evt_m[k][c] = (m == 2'b11) || (m == 2'b01 && lvl_m[k][c]) || (m == 2'b10 && !lvl_m[k][c]);
        end
        busy_m[k][c] = (ih[k][c][ih_n[k] - ST[k]] != lvl_m[k][c]);
      end
    end
  endtask

  // Per-cycle comparison of every instance against the model
  initial begin
    logic [5:0] o, ex, mk;
    for (int k = 0; k < NI; k++) model_reset(k);
    forever begin
      @(posedge clk);
      for (int k = 0; k < NI; k++) model_edge(k);
      #1;
      for (int k = 0; k < NI; k++) begin
        o  = dut_out(k);
        ex = {lvl_m[k][1], lvl_m[k][0], evt_m[k][1], evt_m[k][0], busy_m[k][1], busy_m[k][0]};
        mk = (WD[k] == 2) ? 6'b111111 : 6'b010101;
        n_checks++;
        if ((o & mk) !== (ex & mk)) begin
          n_errors++;
          $display("FAIL model_u%0d @%0t: got lvl/evt/busy=%b expected %b", k, $time, o & mk, ex & mk);
        end
      end
    end
  end

  initial begin
    int busy_n, lvl_n, evt_n, rise_e, fall_e, ev0_e, ev1_e, ev0_n, ev1_n;
    logic [5:0] o;
    rst_v = '1;
    for (int k = 0; k < NI; k++) ain[k] = 2'b00;
    @(negedge clk);
    #1;
    chk("u0_reset_state", int'(dut_out(0)), 0);
    chk("u2_reset_state", int'(dut_out(2)), 6'b110000);

    // defaults: channel-0 step, released together with reset; u2 holds 00 against RESET_VAL 11
    @(negedge clk);
    rst_v  = '0;
    ain[0] = 2'b01;
    @(posedge clk); #1;
    chk("u2_no_evt_release", int'(dut_out(2) & 6'b001100), 0);
    chk("u0_lvl_e1", int'(l0), 0);
    @(posedge clk); #1;
    chk("u0_lvl_e2", int'(l0), 0);
    chk("u2_busy_e2", int'(b2), 3);
    @(posedge clk); #1;
    chk("u0_lvl_e3", int'(l0), 1);
    chk("u0_evt_e3", int'(e0), 1);
    chk("u2_lvl_e3", int'(l2), 0);
    chk("u2_evt_e3", int'(e2), 0);
    @(posedge clk); #1;
    chk("u0_evt_e4", int'(e0), 0);

    // STAGES=3 FILTER=2: 2-cycle glitch rejected
    busy_n = 0; lvl_n = 0; evt_n = 0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk); ain[1] = (e <= 2) ? 2'b01 : 2'b00;
      @(posedge clk); #1;
      o = dut_out(1);
      busy_n += int'(o[0]); lvl_n += int'(o[4]); evt_n += int'(o[2]);
    end
    chk("u1_glitch_busy", busy_n, 2);
    chk("u1_glitch_lvl", lvl_n, 0);
    chk("u1_glitch_evt", evt_n, 0);

    // 5-cycle pulse accepted: rise at edge 6, fall 5 edges after the input falls
    rise_e = 0; fall_e = 0; evt_n = 0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk); ain[1] = (e <= 5) ? 2'b01 : 2'b00;
      @(posedge clk); #1;
      o = dut_out(1);
      evt_n += int'(o[2]);
      if (rise_e == 0 && o[4]) rise_e = e;
      if (rise_e != 0 && fall_e == 0 && !o[4]) fall_e = e;
    end
    chk("u1_rise_edge", rise_e, 6);
    chk("u1_fall_edge", fall_e, 11);
    chk("u1_evt_count", evt_n, 2);

    // MODE {10,01}: ch0 pulses on rise only, ch1 on fall only
    ev0_e = 0; ev1_e = 0; ev0_n = 0; ev1_n = 0;
    for (int e = 1; e <= 24; e++) begin
      @(negedge clk); ain[3] = (e <= 10) ? 2'b11 : 2'b00;
      @(posedge clk); #1;
      if (e3[0]) begin ev0_n++; if (ev0_e == 0) ev0_e = e; end
      if (e3[1]) begin ev1_n++; if (ev1_e == 0) ev1_e = e; end
    end
    chk("u3_ch0_edge", ev0_e, 3);
    chk("u3_ch0_count", ev0_n, 1);
    chk("u3_ch1_edge", ev1_e, 13);
    chk("u3_ch1_count", ev1_n, 1);

    // FILTER=4: reset while the counter sits at 3
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk); ain[4] = 2'b01;
      @(posedge clk);
    end
    #1;
    chk("u4_pending", int'(dut_out(4)), 6'b000001);
    @(negedge clk); rst_v[4] = 1'b1;
    #1;
    chk("u4_reset_mid", int'(dut_out(4)), 0);
    @(negedge clk); rst_v[4] = 1'b0;
    rise_e = 0; evt_n = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      evt_n += int'(e4[0]);
      if (rise_e == 0 && l4[0]) rise_e = e;
    end
    chk("u4_rise_after_reset", rise_e, 7);
    chk("u4_evt_count", evt_n, 1);

    // FILTER=0 any-edge: toggle every cycle, pulse every cycle
    evt_n = 0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk); ain[5] = {1'b0, e[0]};
      @(posedge clk); #1;
      if (e >= 3) evt_n += int'(e5);
      if (e == 3) chk("u5_lvl_e3", int'(l5), 1);
      if (e == 4) chk("u5_lvl_e4", int'(l5), 0);
    end
    chk("u5_evt_every_cycle", evt_n, 14);

    repeat (6) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
